// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   Memory / branch-resolution stage that follows the ALU. It accepts one
//   executed instruction per handshake. It latches the ZN flags and resolves
//   branches, subroutine calls and returns through a small circular return
//   stack. It runs LOAD/STORE over a req/ack memory port and drives the
//   writeback, OUT-port and PC-redirect strobes.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   in_op, in_result, in_zn  opcode (ALU mode encoding), ALU result, {Z,N}
//   in_rd, in_addr, in_data  dest register, address/target, store data/imm
//   in_cond, in_pc_next      BR.Z/N select {Z,N}, link address for BR.SUB
//   mem_*                    memory request (held until ack) and completion
//   wb_*                     register writeback strobe
//   out_valid, out_data      OUT-port strobe
//   br_taken, br_target      PC redirect strobe
//   flags                    latched {Z,N}
module ex_mem_stage #(
  parameter int RET_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [7:0] in_result,
  input  logic [1:0] in_zn,
  input  logic [1:0] in_rd,
  input  logic [7:0] in_addr,
  input  logic [7:0] in_data,
  input  logic [1:0] in_cond,
  input  logic [7:0] in_pc_next,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       wb_valid,
  output logic [1:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       br_taken,
  output logic [7:0] br_target,
  output logic [1:0] flags
);

  localparam int PW = $clog2(RET_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RET_DEPTH);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    ret_stack_q [RET_DEPTH];
  logic [PW-1:0] sp_q, sp_d;      // next free slot
  logic [PW:0]   cnt_q, cnt_d;    // valid entries, saturates at RET_DEPTH
  logic [PW-1:0] sp_m1;
  logic          push_en;
  logic          accept;

  logic       mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic       ld_q, ld_d;         // pending access is a LOAD
  logic [1:0] ld_rd_q, ld_rd_d;
  logic       wb_valid_q, wb_valid_d;
  logic [1:0] wb_rd_q, wb_rd_d;
  logic [7:0] wb_data_q, wb_data_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       br_taken_q, br_taken_d;
  logic [7:0] br_target_q, br_target_d;
  logic [1:0] flags_q, flags_d;

  assign in_ready = (state_q == IDLE);
  // An instruction offered while a redirect is visible is on the wrong path.
  assign accept   = in_valid & in_ready & ~br_taken_q;
  assign sp_m1    = sp_q - PW'(1);

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    cnt_d       = cnt_q;
    push_en     = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_d        = ld_q;
    ld_rd_d     = ld_rd_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    flags_d     = flags_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (in_op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
              wb_valid_d = 1'b1;
              wb_rd_d    = in_rd;
              wb_data_d  = in_result;
              flags_d    = in_zn;
            end
            4'h6: begin
              out_valid_d = 1'b1;
              out_data_d  = in_result;
            end
            4'h7, 4'h8: begin
              wb_valid_d = 1'b1;
              wb_rd_d    = in_rd;
              wb_data_d  = in_result;
            end
            4'hF: begin
              wb_valid_d = 1'b1;
              wb_rd_d    = in_rd;
              wb_data_d  = in_data;
            end
            4'h9: begin
              br_taken_d  = 1'b1;
              br_target_d = in_addr;
            end
            4'hA: begin
              // Uses the flags as they were before this edge.
              if ((in_cond & flags_q) != 2'b00) begin
                br_taken_d  = 1'b1;
                br_target_d = in_addr;
              end
            end
            4'hB: begin
              // Full stack: the push overwrites the oldest slot.
              push_en     = 1'b1;
              sp_d        = sp_q + PW'(1);
              if (cnt_q != DEPTH_C) cnt_d = cnt_q + 1'b1;
              br_taken_d  = 1'b1;
              br_target_d = in_addr;
            end
            4'hC: begin
              br_taken_d = 1'b1;
              if (cnt_q != '0) begin
                sp_d        = sp_m1;
                cnt_d       = cnt_q - 1'b1;
                br_target_d = ret_stack_q[sp_m1];
              end else begin
                br_target_d = 8'h00;
              end
            end
            4'hD, 4'hE: begin
              state_d    = MEM_WAIT;
              mem_req_d  = 1'b1;
              mem_we_d   = (in_op == 4'hE);
              mem_addr_d = in_addr;
              ld_d       = (in_op == 4'hD);
              ld_rd_d    = in_rd;
              if (in_op == 4'hE) mem_wdata_d = in_data;
            end
            default: ;
          endcase
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (ld_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ld_rd_q;
            wb_data_d  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 8'h00;
      ld_q        <= 1'b0;
      ld_rd_q     <= 2'b00;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 2'b00;
      wb_data_q   <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      br_taken_q  <= 1'b0;
      br_target_q <= 8'h00;
      flags_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_q        <= ld_d;
      ld_rd_q     <= ld_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      flags_q     <= flags_d;
    end
  end

  // Stack contents need no reset: emptiness is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push_en && !rst) ret_stack_q[sp_q] <= in_pc_next;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign flags     = flags_q;

endmodule
